// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock divider and its period meter.
`default_nettype none

package clkdiv_pkg;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_AVG_LOG2 = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } meas_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus edge register for an asynchronous input.
`default_nettype none

module sync_edge_det (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= sig_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

`default_nettype wire

// File: rtl/clock_period_meter.sv
// Measures averaged period and last high time of a slow asynchronous clock
// in system-clock cycles, with a sticky no-edge timeout.
`default_nettype none

module clock_period_meter
  import clkdiv_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  localparam int                ACC_W     = CNT_W + AVG_LOG2;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [AVG_LOG2:0] NPER_ONE  = (AVG_LOG2 + 1)'(1);
  localparam logic [AVG_LOG2:0] NPER_FULL = (AVG_LOG2 + 1)'(1 << AVG_LOG2);

  meas_state_t state, next_state;

  logic             s;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] hcnt;
  logic             high_run;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [AVG_LOG2:0] nper;
  logic [AVG_LOG2:0] nper_inc;

  logic start;
  logic edge_seen;
  logic close_win;
  logic tmo;

  sync_edge_det u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .sig_in (sig_in),
    .level  (s),
    .rise   (rise),
    .fall   (fall)
  );

  assign acc_sum  = acc + ACC_W'(pcnt);
  assign nper_inc = nper + NPER_ONE;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // A rise coinciding with an all-ones count is checked first so the edge wins.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    edge_seen  = 1'b0;
    close_win  = 1'b0;
    tmo        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) next_state = ST_ARM;
      end
      ST_ARM: begin
        if (!en) begin
          next_state = ST_IDLE;
        end else if (rise) begin
          next_state = ST_MEAS;
          start      = 1'b1;
        end
      end
      ST_MEAS: begin
        if (!en) begin
          next_state = ST_IDLE;
        end else if (rise) begin
          edge_seen = 1'b1;
          close_win = (nper_inc == NPER_FULL);
        end else if (pcnt == CNT_MAX) begin
          tmo        = 1'b1;
          next_state = ST_ARM;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pcnt      <= '0;
      hcnt      <= '0;
      high_run  <= 1'b0;
      acc       <= '0;
      nper      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        pcnt     <= '0;
        hcnt     <= '0;
        high_run <= 1'b0;
        acc      <= '0;
        nper     <= '0;
        timeout  <= 1'b0;
      end else if (start || edge_seen) begin
        pcnt     <= CNT_ONE;
        hcnt     <= CNT_ONE;
        high_run <= 1'b1;
        if (start || close_win) begin
          acc  <= '0;
          nper <= '0;
        end else begin
          acc  <= acc_sum;
          nper <= nper_inc;
        end
        if (close_win) begin
          period    <= CNT_W'(acc_sum >> AVG_LOG2);
          high_time <= hcnt;
          valid     <= 1'b1;
          timeout   <= 1'b0;
        end
      end else if (tmo) begin
        timeout  <= 1'b1;
        pcnt     <= '0;
        hcnt     <= '0;
        high_run <= 1'b0;
        acc      <= '0;
        nper     <= '0;
      end else if (state == ST_MEAS) begin
        pcnt <= pcnt + CNT_ONE;
        // Only the first high phase after the rise contributes to the high time.
        if (fall)                high_run <= 1'b0;
        else if (high_run && s)  hcnt     <= hcnt + CNT_ONE;
      end else begin
        pcnt     <= '0;
        hcnt     <= '0;
        high_run <= 1'b0;
        acc      <= '0;
        nper     <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/clock_period_meter.md
# clock_period_meter

Measures an asynchronous divided clock (the output of the team's clock divider, or any slow square wave) against the system clock. It reports the averaged period and the last high time, both in system-clock cycles. It is the receive-side check for the divider: it sits on a TinyTapeout input pin, so a bench or a second tile can verify the division ratio on silicon. It is fully synchronous to `clk_in`, and `sig_in` is resynchronised internally.

## Interface
- `CNT_W`, default 16: width of the per-period counter and of the reported values.
- `AVG_LOG2`, default 2: the block averages over 2^AVG_LOG2 consecutive periods.
- `clk_in` input, 1 bit: system clock. All logic runs on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `en` input, 1 bit: measurement enable. Level-sensitive and synchronous.
- `sig_in` input, 1 bit: clock under test. It is asynchronous to `clk_in`.
- `period` output, CNT_W bits: averaged period of the last completed window.
- `high_time` output, CNT_W bits: high-phase length of the last period in that window.
- `valid` output, 1 bit: one-cycle pulse when `period` and `high_time` update.
- `timeout` output, 1 bit: sticky flag meaning no rising edge arrived within 2^CNT_W−1 cycles.

## Operation
- Input path: `sig_in` goes through a 2-FF synchroniser, then a registered copy for edge detection. This produces the `rise` and `fall` pulses and the synchronised level `s`.
- States: IDLE, ARM, MEAS.
  - IDLE: counters cleared. Moves to ARM when `en` is 1.
  - ARM: waits for `rise`. On `rise`, go to MEAS with `pcnt` = 1, `hcnt` = 1, `acc` = 0, `nper` = 0.
  - MEAS: every cycle `pcnt` increments by 1. `hcnt` increments while `s` is 1 and holds once `s` is 0. On `rise`:
    - `acc` += `pcnt` and `nper` increments.
    - `pcnt` and `hcnt` restart at 1.
    - If `nper` reaches 2^AVG_LOG2, then `period` ← (`acc` + `pcnt`) >> AVG_LOG2 (truncating), `high_time` ← `hcnt`, `valid` = 1, `timeout` ← 0, `acc` ← 0, `nper` ← 0.
    - Measurement is continuous: the closing edge of one window opens the next window.
- Width rule: `acc` is CNT_W+AVG_LOG2 bits wide and cannot overflow.
- Timeout: if `pcnt` equals all-ones in MEAS without `rise`, then `timeout` ← 1, the partial window is discarded, and the FSM goes to ARM. `period` and `high_time` hold their old values.
- `rise` in the same cycle that `pcnt` is all-ones: the edge wins and is counted normally, with no timeout.
- `en` dropping to 0 in any state: go to IDLE on the next edge and discard the partial window. `valid` = 0 and `timeout` is cleared. `period` and `high_time` hold.
- Reset, async or mid-operation: state = IDLE, and every output = 0 (`period`, `high_time`, `valid`, `timeout`). Synchroniser flops are cleared to 0.
- A constant-high `sig_in` also times out, because it has no rises.
- A duty cycle of 0 high cycles is impossible, since a rise implies at least one high sample.

## Timing
- Synchroniser plus edge detect: the `rise` pulse appears 3 `clk_in` edges after the `sig_in` transition, ±1 cycle metastability uncertainty.
- `valid` asserts in the cycle after the `rise` that closes a window. `period` and `high_time` are registered and stable from that cycle on.
- First `valid` after `en` goes high: 1 arming rise plus 2^AVG_LOG2 full periods, plus 4 cycles.
- Minimum measurable period is 2 cycles (high ≥ 1, low ≥ 1). Maximum is 2^CNT_W−1.
- `valid` is never asserted for two consecutive cycles when the period is ≥ 2.

## Structure
- Shared package/header `clkdiv_pkg`:
  - FSM state encoding (IDLE = 0, ARM = 1, MEAS = 2).
  - Default `CNT_W` and `AVG_LOG2`.
  - It is also usable by the divider's top-level wrapper.
- Sub-module `sync_edge_det`: 2-FF synchroniser, edge register, and `rise`/`fall`/level outputs. Async active-high reset.
- The top (FSM, counters, accumulator, output registers) is a single module. No other hierarchy.

## Test plan
- Divide-by-4 square wave (2 high / 2 low), `en` = 1, AVG_LOG2 = 2 → `valid` pulses every 16 cycles, with `period` = 4 and `high_time` = 2. `timeout` stays 0.
- Period alternating 9/10 (high 5, low 4/5) → `period` = 38 >> 2 = 9 (truncation). `high_time` = 5.
- CNT_W = 8, `sig_in` held at 0 after one rise → `timeout` = 1 exactly 255 cycles after the arming rise, and `period` is unchanged. Restarting a 6-cycle wave clears `timeout` at the next `valid` (`period` = 6).
- `en` dropped mid-window, then raised 10 cycles later → no `valid` for the dropped window. The next `valid` arrives 1 arming rise + 4 periods later, with the correct value.
- Async `rst` pulse mid-MEAS, between clock edges → all outputs are 0 immediately. After release, the block measures again from IDLE/ARM.
- `sig_in` = `clk_in`/2 (minimum period) → `period` = 2 and `high_time` = 1. `valid` is never high on two consecutive cycles.
